// File: rtl/rtd_ctrl_if.sv
// Handshake bundle for the reaction-time controller: round request and button in,
// stimulus LED, BCD result, state code and status flags out.
interface rtd_ctrl_if;
    logic       start;
    logic       bt;
    logic       led;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic [2:0] state;
    logic       false_start;
    logic       timeout;

    modport master (
        output start, bt,
        input  led, bcd1, bcd0, state, false_start, timeout
    );

    modport slave (
        input  start, bt,
        output led, bcd1, bcd0, state, false_start, timeout
    );
endinterface

// File: rtl/rtd_ctrl.sv
// Reaction-time game controller: random pre-stimulus wait, lit LED, then a
// two-digit BCD count of 10 ms ticks until the (active-low) button is pressed.
module rtd_ctrl #(
    parameter int TICK_DIV = 1000000,
    parameter int MIN_WAIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    rtd_ctrl_if.slave  bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        REACT = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t      cur;
    logic        bt_meta;
    logic        bt_sync;
    logic        start_q;
    logic [7:0]  lfsr;
    logic [PW-1:0] presc;
    logic [8:0]  wait_cnt;
    logic [3:0]  bcd1_q;
    logic [3:0]  bcd0_q;
    logic        false_start_q;
    logic        timeout_q;

    logic pressed;
    logic start_edge;
    logic tick;
    logic lfsr_fb;

    assign pressed    = ~bt_sync;
    assign start_edge = bus.start & ~start_q;
    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // The prescaler free-runs; entering WAIT or REACT restarts it so the first
    // tick lands a full TICK_DIV cycles after entry. Press beats a coincident tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur           <= IDLE;
            bt_meta       <= 1'b1;
            bt_sync       <= 1'b1;
            start_q       <= 1'b0;
            lfsr          <= 8'hA5;
            presc         <= '0;
            wait_cnt      <= '0;
            bcd1_q        <= 4'd0;
            bcd0_q        <= 4'd0;
            false_start_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            bt_meta <= bus.bt;
            bt_sync <= bt_meta;
            start_q <= bus.start;
            lfsr    <= {lfsr[6:0], lfsr_fb};
            presc   <= tick ? '0 : presc + 1'b1;

            case (cur)
                IDLE, DONE, FAULT: begin
                    if (start_edge) begin
                        cur           <= WAIT;
                        wait_cnt      <= 9'(MIN_WAIT) + {1'b0, lfsr};
                        bcd1_q        <= 4'd0;
                        bcd0_q        <= 4'd0;
                        false_start_q <= 1'b0;
                        timeout_q     <= 1'b0;
                        presc         <= '0;
                    end
                end
                WAIT: begin
                    if (pressed) begin
                        cur           <= FAULT;
                        false_start_q <= 1'b1;
                        bcd1_q        <= 4'hF;
                        bcd0_q        <= 4'hF;
                    end else if (tick) begin
                        wait_cnt <= wait_cnt - 1'b1;
                        if (wait_cnt == 9'd1) begin
                            cur   <= REACT;
                            presc <= '0;
                        end
                    end
                end
                REACT: begin
                    if (pressed) begin
                        cur <= DONE;
                    end else if (tick) begin
                        if (bcd1_q == 4'd9 && bcd0_q == 4'd9) begin
                            cur       <= DONE;
                            timeout_q <= 1'b1;
                        end else if (bcd0_q == 4'd9) begin
                            bcd0_q <= 4'd0;
                            bcd1_q <= bcd1_q + 4'd1;
                        end else begin
                            bcd0_q <= bcd0_q + 4'd1;
                        end
                    end
                end
                default: cur <= IDLE;
            endcase
        end
    end

    assign bus.state       = cur;
    assign bus.led         = (cur != REACT);
    assign bus.bcd1        = bcd1_q;
    assign bus.bcd0        = bcd0_q;
    assign bus.false_start = false_start_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_rtd_ctrl.sv
// Directed bench for rtd_ctrl with TICK_DIV=4, MIN_WAIT=2: table of reaction
// rounds plus hand-written timeout, false-start, restart and reset sequences.
module tb_rtd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rtd_ctrl_if bus ();

    rtd_ctrl #(.TICK_DIV(4), .MIN_WAIT(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR: same polynomial and seed, stepping every cycle from reset.
    logic [7:0] lfsr_m;
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 8'hA5;
        else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end

    typedef struct {
        int         n;
        int         offset;
        logic [3:0] b1;
        logic [3:0] b0;
    } vec_t;

    vec_t vecs[5];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    logic led_low   = 1'b0;

    task automatic check_output(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.led === 1'b0) led_low = 1'b1;
        end
    endtask

    // Raise start at a negedge; returns the expected wait in ticks and leaves
    // the bench at the negedge following WAIT entry.
    task automatic apply_stimulus(output int w);
        w = 2 + int'(lfsr_m);
        bus.start = 1'b1;
        cycles(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_react(input int w, input int k0, input string name);
        int k;
        k = k0;
        while (bus.led !== 1'b0 && k < 4 * w + 8) begin
            cycles(1);
            k++;
        end
        check_output({name, " led latency"}, k, 4 * w);
    endtask

    task automatic check_done(input string name, input int st, input int b1, input int b0,
                              input int fs, input int to);
        check_output({name, " state"}, int'(bus.state), st);
        check_output({name, " bcd1"}, int'(bus.bcd1), b1);
        check_output({name, " bcd0"}, int'(bus.bcd0), b0);
        check_output({name, " led"}, int'(bus.led), 1);
        check_output({name, " false_start"}, int'(bus.false_start), fs);
        check_output({name, " timeout"}, int'(bus.timeout), to);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int w;
        string nm;

        vecs[0] = '{37, 0, 4'd3, 4'd7};
        vecs[1] = '{9,  1, 4'd0, 4'd9};
        vecs[2] = '{9,  2, 4'd1, 4'd0};
        vecs[3] = '{0,  0, 4'd0, 4'd0};
        vecs[4] = '{12, 0, 4'd1, 4'd2};

        bus.start = 1'b0;
        bus.bt    = 1'b1;
        #12;
        check_done("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(4);
        check_output("idle after reset state", int'(bus.state), 0);

        // Reaction rounds: press n ticks into REACT, offset 1 lands on the next tick.
        for (int i = 0; i < 5; i++) begin
            nm = $sformatf("round%0d", i);
            apply_stimulus(w);
            check_output({nm, " wait entry"}, int'(bus.state), 1);
            wait_react(w, 0, nm);
            cycles(4 * vecs[i].n + vecs[i].offset);
            bus.bt = 1'b0;
            cycles(6);
            check_done(nm, 3, int'(vecs[i].b1), int'(vecs[i].b0), 0, 0);
            bus.bt = 1'b1;
            cycles(3);
        end

        // Timeout round with carry check on the way.
        apply_stimulus(w);
        wait_react(w, 0, "timeout");
        cycles(36);
        check_output("carry pre bcd1", int'(bus.bcd1), 0);
        check_output("carry pre bcd0", int'(bus.bcd0), 9);
        cycles(4);
        check_output("carry post bcd1", int'(bus.bcd1), 1);
        check_output("carry post bcd0", int'(bus.bcd0), 0);
        cycles(359);
        check_output("before 100th tick state", int'(bus.state), 2);
        check_output("before 100th tick bcd0", int'(bus.bcd0), 9);
        cycles(1);
        check_done("timeout", 3, 9, 9, 0, 1);
        cycles(12);
        check_done("timeout hold", 3, 9, 9, 0, 1);

        // Restart from DONE with timeout, then false start during WAIT.
        apply_stimulus(w);
        check_output("restart done state", int'(bus.state), 1);
        check_output("restart done timeout", int'(bus.timeout), 0);
        check_output("restart done bcd1", int'(bus.bcd1), 0);
        check_output("restart done bcd0", int'(bus.bcd0), 0);
        led_low = 1'b0;
        cycles(2);
        bus.bt = 1'b0;
        cycles(5);
        check_done("false start", 4, 15, 15, 1, 0);
        check_output("false start led stayed high", int'(led_low), 0);
        bus.bt = 1'b1;
        cycles(3);

        // Restart from FAULT; a second start edge inside WAIT must not reload wait_cnt.
        apply_stimulus(w);
        check_output("restart fault state", int'(bus.state), 1);
        check_output("restart fault false_start", int'(bus.false_start), 0);
        check_output("restart fault bcd1", int'(bus.bcd1), 0);
        check_output("restart fault bcd0", int'(bus.bcd0), 0);
        cycles(2);
        bus.start = 1'b1;
        cycles(1);
        bus.start = 1'b0;
        wait_react(w, 3, "start in wait");
        cycles(20);
        bus.bt = 1'b0;
        cycles(5);
        check_done("start in wait", 3, 0, 5, 0, 0);
        bus.bt = 1'b1;
        cycles(3);

        // Press lands exactly on the expiring WAIT tick: press wins.
        apply_stimulus(w);
        led_low = 1'b0;
        cycles(4 * w - 3);
        bus.bt = 1'b0;
        cycles(6);
        check_done("expiring tick press", 4, 15, 15, 1, 0);
        check_output("expiring tick led stayed high", int'(led_low), 0);
        bus.bt = 1'b1;
        cycles(3);

        // Asynchronous reset mid-REACT at 4/2.
        apply_stimulus(w);
        wait_react(w, 0, "async reset");
        cycles(4 * 42 + 2);
        check_output("pre reset bcd1", int'(bus.bcd1), 4);
        check_output("pre reset bcd0", int'(bus.bcd0), 2);
        #2 rst = 1'b1;
        #1;
        check_done("async reset", 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        cycles(5);
        check_output("after reset stays idle", int'(bus.state), 0);
        apply_stimulus(w);
        check_output("post reset start state", int'(bus.state), 1);
        check_output("post reset start bcd1", int'(bus.bcd1), 0);
        check_output("post reset start bcd0", int'(bus.bcd0), 0);
        wait_react(w, 0, "post reset");
        bus.bt = 1'b0;
        cycles(5);
        check_done("post reset round", 3, 0, 0, 0, 0);
        bus.bt = 1'b1;
        cycles(3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/rtd_ctrl.md
RTD_CTRL -- requirements
Module: rtd_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, clk cycles per timing tick (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter MIN_WAIT, default 100, minimum random pre-stimulus wait in ticks; legal range 1..255.
REQ-003 Port clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port start  input  1  round request; level input, rising edge detected internally.
REQ-006 Port bt  input  1  reaction button, active-low (0 = pressed), asynchronous to clk.
REQ-007 Port led  output  1  stimulus LED, active-low (0 = lit).
REQ-008 Port bcd1  output  4  result tens digit (BCD, units of 100 ms).
REQ-009 Port bcd0  output  4  result units digit (BCD, units of 10 ms).
REQ-010 Port state  output  3  FSM state code: IDLE=0, WAIT=1, REACT=2, DONE=3, FAULT=4.
REQ-011 Port false_start  output  1  high while in FAULT.
REQ-012 Port timeout  output  1  high in DONE when the round ended by saturation.

Function
REQ-013 bt SHALL pass through a 2-flop synchronizer; "pressed" means the synchronized value = 0, giving 2-cycle input latency.
REQ-014 start SHALL be registered once; a start edge is current start = 1 with previous sample = 0.
REQ-015 An 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5, SHALL advance every clk cycle in all states.
REQ-016 A prescaler SHALL count 0..TICK_DIV-1 and assert a one-cycle tick at TICK_DIV-1. It SHALL be cleared on entry to WAIT and to REACT, so the first tick occurs TICK_DIV cycles after entry.
REQ-017 IDLE: on start edge, go to WAIT, load wait_cnt = MIN_WAIT + lfsr (9-bit, no overflow), and clear bcd1/bcd0 to 0/0.
REQ-018 WAIT: wait_cnt SHALL decrement on each tick. When a tick arrives with wait_cnt = 1, go to REACT.
REQ-019 WAIT: pressed SHALL go to FAULT, set false_start = 1, and set bcd1 = bcd0 = 4'hF.
REQ-020 WAIT: if pressed and the expiring tick coincide, press wins and the FSM goes to FAULT.
REQ-021 REACT: led = 0. Each tick SHALL increment the 2-digit BCD count; bcd0 wraps 9->0 with a carry into bcd1.
REQ-022 REACT: pressed SHALL go to DONE with the count frozen. A press coinciding with a tick SHALL go to DONE with no increment.
REQ-023 REACT: a tick at count 9/9 SHALL go to DONE with the count held at 9/9 and timeout = 1.
REQ-024 DONE and FAULT: all outputs hold. A start edge SHALL go to WAIT per REQ-017 and clear false_start and timeout.
REQ-025 Start edges in WAIT or REACT SHALL be ignored. bt in IDLE, DONE or FAULT SHALL be ignored.
REQ-026 led SHALL be 1 in every state except REACT. All outputs SHALL be registered, except led and state, which decode directly from the state register.

Reset
REQ-027 rst = 1 SHALL immediately, without a clock, force: state = IDLE(0), led = 1, bcd1 = bcd0 = 0, false_start = 0, timeout = 0, LFSR = 8'hA5, prescaler = 0, wait_cnt = 0, synchronizer flops = 1, start register = 0.
REQ-028 Reset asserted mid-round (any state) SHALL abandon the round. After release, the block stays in IDLE until a new start edge.

Verification (bench with TICK_DIV=4, MIN_WAIT=2)
REQ-029 Normal round: start edge, hold bt = 1 -> led falls exactly (2 + LFSR value sampled at the start edge) x 4 cycles after WAIT entry. Press bt 37 ticks into REACT -> state = 3, bcd1/bcd0 = 3/7, led = 1, flags 0.
REQ-030 False start: press bt during WAIT, including on the expiring tick -> state = 4, false_start = 1, bcd = F/F, led never goes low.
REQ-031 Timeout: no press in REACT -> after the 100th tick, state = 3, timeout = 1, bcd = 9/9. Further ticks cause no change.
REQ-032 Coincidence: bt press synchronized on the same cycle as the tick at count 0/9 -> result 0/9, not 1/0. Also check the carry case 0/9 -> 1/0 with no press.
REQ-033 Async reset: assert rst between clk edges while in REACT at count 4/2 -> outputs at REQ-027 values before the next posedge. After release, start edge -> WAIT with bcd = 0/0.
REQ-034 Restart: start edge from DONE (timeout = 1) and from FAULT -> state = 1 next cycle, flags = 0, bcd = 0/0. A start edge during WAIT leaves wait_cnt unchanged.
